// File: rtl/uio_bus_arbiter.sv
// rtl/uio_bus_arbiter.sv - round-robin owner arbiter for the shared uio pad bus (UIO_ARB_TIMEOUT_EN adds hold-time preemption)
module uio_bus_arbiter #(
    parameter int MAX_HOLD    = 16,
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [7:0] dat_a,
    input  logic [7:0] dat_b,
    input  logic [7:0] uio_in,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    localparam int TURN_W = $clog2(TURN_CYCLES + 1);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t            state, state_next, pick;
    logic              last_b, last_b_next;
    logic [TURN_W-1:0] turn_cnt, turn_cnt_next;
    logic              preempt_a, preempt_b;

`ifdef UIO_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
    logic              hold_full;

    assign hold_full = (hold_cnt >= HOLD_W'(MAX_HOLD));
    assign preempt_a = hold_full && req_b;
    assign preempt_b = hold_full && req_a;

    // Counts from 1 on entry to an owner state, saturating at MAX_HOLD.
    always_comb begin
        hold_cnt_next = '0;
        if (state_next == OWN_A || state_next == OWN_B) begin
            if (state_next != state) begin
                hold_cnt_next = HOLD_W'(1);
            end else if (!hold_full) begin
                hold_cnt_next = hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt_next = hold_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_next;
        end
    end
`else
    logic [HOLD_W-1:0] unused_hold;

    assign unused_hold = '0;
    assign preempt_a   = 1'b0;
    assign preempt_b   = 1'b0;
`endif

    // Shared grant decision for IDLE and TURN expiry; a tie goes to whoever did not own last.
    always_comb begin
        pick = IDLE;
        if (ena && req_a && (!req_b || last_b)) begin
            pick = OWN_A;
        end else if (ena && req_b) begin
            pick = OWN_B;
        end
    end

    always_comb begin
        state_next    = state;
        turn_cnt_next = '0;
        last_b_next   = last_b;
        case (state)
            IDLE:  state_next = pick;
            OWN_A: if (!(req_a && ena) || preempt_a) state_next = TURN;
            OWN_B: if (!(req_b && ena) || preempt_b) state_next = TURN;
            TURN:  if (turn_cnt >= TURN_W'(TURN_CYCLES)) state_next = pick;
            default: state_next = IDLE;
        endcase

        if (state_next == TURN) begin
            if (state != TURN) begin
                turn_cnt_next = TURN_W'(1);
            end else if (turn_cnt < TURN_W'(TURN_CYCLES)) begin
                turn_cnt_next = turn_cnt + TURN_W'(1);
            end else begin
                turn_cnt_next = turn_cnt;
            end
        end

        if (state_next == OWN_A && state != OWN_A) last_b_next = 1'b0;
        if (state_next == OWN_B && state != OWN_B) last_b_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            turn_cnt <= '0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_next;
            last_b   <= last_b_next;
            turn_cnt <= turn_cnt_next;
            gnt_a    <= (state_next == OWN_A);
            gnt_b    <= (state_next == OWN_B);
            if (state == IDLE && ena) begin
                rx_data  <= uio_in;
                rx_valid <= 1'b1;
            end else begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Pads follow the registered grants; data is a live pass-through of the owner's byte.
    assign uio_oe  = (gnt_a || gnt_b) ? 8'hFF : 8'h00;
    assign uio_out = gnt_a ? dat_a : (gnt_b ? dat_b : 8'h00);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb/tb_uio_bus_arbiter.sv - scoreboard bench for uio_bus_arbiter
module tb_uio_bus_arbiter;

    localparam int TURN_CYCLES = 1;
    localparam int MAX_HOLD    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [7:0] dat_a = 8'h00;
    logic [7:0] dat_b = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic       gnt_a, gnt_b, rx_valid;
    logic [7:0] uio_out, uio_oe, rx_data;

    uio_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .TURN_CYCLES(TURN_CYCLES)) dut (
        .clk(clk), .rst(rst), .ena(ena), .req_a(req_a), .req_b(req_b),
        .dat_a(dat_a), .dat_b(dat_b), .uio_in(uio_in),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .uio_out(uio_out), .uio_oe(uio_oe),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ga;
        logic       gb;
        logic       rxv;
        logic [7:0] rxd;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] rx_exp = 8'h00;
    bit         mon_en = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, queue the expected post-edge outputs, then pop and compare.
    task automatic cyc(input logic r, input logic e, input logic ra, input logic rb,
                       input logic [7:0] uin, input logic xga, input logic xgb, input logic xrv);
        exp_t x;
        rst = r; ena = e; req_a = ra; req_b = rb; uio_in = uin;
        dat_a = 8'($urandom); dat_b = 8'($urandom);
        if (r) rx_exp = 8'h00;
        else if (xrv) rx_exp = uin;
        sb.push_back('{xga, xgb, xrv, rx_exp});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("gnt_a", gnt_a, x.ga);
        check("gnt_b", gnt_b, x.gb);
        check("uio_oe", uio_oe, (x.ga || x.gb) ? 8'hFF : 8'h00);
        check("uio_out", uio_out, x.ga ? dat_a : (x.gb ? dat_b : 8'h00));
        check("rx_valid", rx_valid, x.rxv);
        check("rx_data", rx_data, x.rxd);
    endtask

    logic [1:0] prev_g = 2'b00;
    int         idle_run = 0;
    bit         had_grant = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("gnt_excl", gnt_a && gnt_b, 0);
            check("oe_iff_gnt", uio_oe, (gnt_a || gnt_b) ? 8'hFF : 8'h00);
            if ({gnt_a, gnt_b} != 2'b00 && {gnt_a, gnt_b} != prev_g && had_grant)
                check("turn_gap", (prev_g == 2'b00) && (idle_run >= TURN_CYCLES), 1);
            if (gnt_a || gnt_b) begin
                idle_run  = 0;
                had_grant = 1;
            end else begin
                idle_run++;
            end
            prev_g = {gnt_a, gnt_b};
            if (rst) had_grant = 0;
        end
    end

    initial begin
        logic xa, xb;
        cyc(1, 1, 0, 0, 8'h00, 0, 0, 0);
        mon_en = 1;
        cyc(0, 1, 0, 0, 8'h5A, 0, 0, 1);
        cyc(0, 0, 0, 0, 8'hA5, 0, 0, 0);
        cyc(0, 1, 0, 0, 8'h11, 0, 0, 1);

        cyc(0, 1, 1, 0, 8'h22, 1, 0, 1);
        repeat (8) cyc(0, 1, 1, 0, 8'($urandom), 1, 0, 0);
        cyc(0, 1, 0, 0, 8'($urandom), 0, 0, 0);
        cyc(0, 1, 0, 0, 8'($urandom), 0, 0, 0);
        cyc(0, 1, 0, 0, 8'h33, 0, 0, 1);

        cyc(1, 1, 0, 0, 8'h00, 0, 0, 0);
        cyc(0, 1, 1, 1, 8'h44, 1, 0, 1);
        cyc(0, 1, 1, 1, 8'($urandom), 1, 0, 0);
        cyc(0, 1, 0, 1, 8'($urandom), 0, 0, 0);
        cyc(0, 1, 0, 1, 8'($urandom), 0, 1, 0);
        cyc(0, 1, 1, 1, 8'($urandom), 0, 1, 0);
        cyc(0, 1, 1, 0, 8'($urandom), 0, 0, 0);
        cyc(0, 1, 1, 0, 8'($urandom), 1, 0, 0);
        cyc(0, 1, 0, 0, 8'($urandom), 0, 0, 0);
        cyc(0, 1, 0, 0, 8'($urandom), 0, 0, 0);
        cyc(0, 1, 0, 0, 8'h55, 0, 0, 1);

        cyc(0, 1, 0, 1, 8'h66, 0, 1, 1);
        cyc(0, 1, 0, 1, 8'($urandom), 0, 1, 0);
        cyc(0, 0, 0, 1, 8'($urandom), 0, 0, 0);
        cyc(0, 0, 0, 1, 8'($urandom), 0, 0, 0);
        cyc(0, 0, 0, 1, 8'($urandom), 0, 0, 0);
        cyc(0, 1, 0, 1, 8'h77, 0, 1, 1);
        cyc(0, 1, 0, 0, 8'($urandom), 0, 0, 0);
        cyc(0, 1, 0, 0, 8'($urandom), 0, 0, 0);

        cyc(0, 1, 1, 0, 8'h88, 1, 0, 1);
        cyc(0, 1, 1, 0, 8'($urandom), 1, 0, 0);
        cyc(1, 1, 1, 0, 8'($urandom), 0, 0, 0);
        cyc(0, 1, 1, 0, 8'h99, 1, 0, 1);
        cyc(0, 1, 0, 0, 8'($urandom), 0, 0, 0);
        cyc(0, 1, 0, 0, 8'($urandom), 0, 0, 0);

        cyc(1, 1, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
`ifdef UIO_ARB_TIMEOUT_EN
            xa = (i < 4) || (i >= 10);
            xb = (i >= 5) && (i < 9);
`else
            xa = 1'b1;
            xb = 1'b0;
`endif
            cyc(0, 1, 1, 1, 8'($urandom), xa, xb, i == 0);
        end
        cyc(0, 1, 0, 0, 8'($urandom), 0, 0, 0);
        cyc(0, 1, 0, 0, 8'($urandom), 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
